linear_layer_start_srl_fifo: RTL and testbench
==============================================

# linear_layer_start_srl_fifo

SRL-based start-token/data FIFO that hands each "start" from a producer task to a consumer task in the Linear_Layer_i4xi4_q dataflow region. It feeds, for example, the PE_i4xi4_pack_2x2 instances. The block holds up to DEPTH entries in an internal shift-register array: an accepted write shifts all entries one slot deeper, and reads select the oldest entry by address. Occupancy control, registered full/empty flags and read-address generation are all local, so the consumer sees a FWFT-style interface with no read latency.

## Interface
Parameters:
- DATA_WIDTH, 1, width of each entry
- ADDR_WIDTH, 1, read-address width; requires 2^ADDR_WIDTH >= DEPTH
- DEPTH, 2, capacity in entries; must be >= 1

Ports:
- ap_clk  in  1  sole clock; all state updates on the rising edge
- ap_rst_n  in  1  reset; asynchronous, active-low
- if_din  in  DATA_WIDTH  write data
- if_write  in  1  write request
- if_full_n  out  1  high = space available
- if_dout  out  DATA_WIDTH  oldest entry
- if_read  in  1  read request
- if_empty_n  out  1  high = data available
- if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- Storage: array srl[0..DEPTH-1].
  - On an accepted write: srl[i+1] <= srl[i] for i = 0..DEPTH-2, and srl[0] <= if_din.
  - Storage has no reset.
- Accepted write (wr_ok) = if_write & if_full_n. Accepted read (rd_ok) = if_read & if_empty_n. Requests made while the matching flag is low are ignored without error.
- Occupancy register cnt. Its state (cnt) is EMPTY (0), PARTIAL (1..DEPTH-1) or FULL (DEPTH).
  - wr_ok only: cnt+1.
  - rd_ok only: cnt-1.
  - Both or neither: unchanged.
- Read address: addr = cnt-1 when cnt > 0, otherwise 0. It is registered alongside cnt and updated with the same rules. Wrap-around never occurs.
- if_dout = srl[addr], combinational from the registered address and storage. It is don't-care while if_empty_n = 0.
- Flags are registered, computed from the next value of cnt:
  - if_empty_n <= (cnt_next != 0)
  - if_full_n <= (cnt_next != DEPTH)
- Simultaneous read and write with 0 < cnt < DEPTH: the shift moves the second-oldest entry into slot addr. Order is preserved and cnt, addr and both flags are unchanged.
- Write while FULL with a read in the same cycle: the write is rejected, because if_full_n is still low. Only the read takes effect.
- Read while EMPTY with a write in the same cycle: the read is rejected. Only the write takes effect.
- DEPTH = 1: addr is constantly 0 and the flags toggle exclusively.
- if_count = cnt.

## Timing
- Reset (async assert; release synchronous to ap_clk is the integrator's responsibility):
  - cnt = 0, addr = 0
  - if_empty_n = 0, if_full_n = 1, if_count = 0
  - if_dout is X-tolerant
- Reset asserted mid-operation immediately discards all entries. Flags return to reset values in the same cycle, without waiting for an edge.
- Write-to-visible latency: 1 cycle. A write accepted at edge t raises if_empty_n and presents the data on if_dout after edge t.
- Read: the consumer samples if_dout in the same cycle it asserts if_read. The next entry appears after the edge.
- Throughput: one write and one read per cycle sustained in PARTIAL.
- No combinational path from if_write or if_read to any output.

## Test plan
- Reset: drive ap_rst_n=0 with no clock edges -> if_empty_n=0, if_full_n=1, if_count=0; release and idle 5 cycles -> unchanged.
- Fill/drain, DEPTH=2: write 1, 0 on consecutive cycles -> if_full_n=0, if_count=2. A third write is ignored. Read twice -> if_dout yields 1 then 0, if_empty_n=0.
- Simultaneous read/write, DEPTH=4: preload A,B; then 6 cycles of write+read with data C..H -> reads return A..F in order and if_count stays 2.
- Boundaries, DEPTH=4: at FULL drive if_write=if_read=1 -> one read only, if_count=3. At EMPTY drive both -> write only, if_count=1, and the data appears next cycle.
- Reset mid-stream: with if_count=3, pulse ap_rst_n low between edges -> flags clear asynchronously. After release, a new write of 1 is read back as 1.
- Random, DEPTH=5, ADDR_WIDTH=3: 2000 cycles of random if_write/if_read against a queue model -> zero data mismatches. Flags and if_count match the model every cycle.

Source files
------------

// File: rtl/linear_layer_start_srl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : linear_layer_start_srl_fifo
//  Purpose  : Shift-register start-token/data FIFO between a producer and a
//             consumer task of the Linear_Layer_i4xi4_q dataflow region.
//             Writes shift every entry one slot deeper. Reads select the
//             oldest entry by a registered address, which gives a first-word
//             fall-through interface with no read latency.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    ap_clk      in   1             rising-edge clock
//    ap_rst_n    in   1             asynchronous active-low reset
//    if_din      in   DATA_WIDTH    write data
//    if_write    in   1             write request (ignored while full)
//    if_full_n   out  1             high = space available (registered)
//    if_dout     out  DATA_WIDTH    oldest entry (don't-care while empty)
//    if_read     in   1             read request (ignored while empty)
//    if_empty_n  out  1             high = data available (registered)
//    if_count    out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
// ============================================================================
module linear_layer_start_srl_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,   // 2**ADDR_WIDTH must cover DEPTH
  parameter int DEPTH      = 2    // capacity in entries, >= 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count
);

  localparam logic [ADDR_WIDTH:0]   c_depth_cnt = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_one_cnt   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_one_addr  = ADDR_WIDTH'(1);

  // Occupancy, read address and flags.
  logic [ADDR_WIDTH:0]   cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q,  full_n_d;

  // Storage array: slot 0 is the newest entry, slot addr_q the oldest.
  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [DATA_WIDTH-1:0] srl_d [DEPTH];

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_dout;

  // Requests are qualified by the registered flags only, so no input reaches
  // an output combinationally.
  assign w_wr_ok = if_write & full_n_q;
  assign w_rd_ok = if_read  & empty_n_q;

  // --------------------------------------------------------------------------
  // Storage shift
  // --------------------------------------------------------------------------
  always_comb begin
    srl_d = srl_q;
    if (w_wr_ok) begin
      srl_d[0] = if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_d[i] = srl_q[i-1];
      end
    end
  end

  // Data slots carry no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge ap_clk) begin
    srl_q <= srl_d;
  end

  // --------------------------------------------------------------------------
  // Occupancy / address / flag next-state
  // --------------------------------------------------------------------------
  // addr tracks cnt-1 (saturating at 0). On a simultaneous read and write the
  // shift moves the second-oldest entry into slot addr_q, so both the count
  // and the address stay put.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10: begin
        cnt_d = cnt_q + c_one_cnt;
        if (cnt_q != '0) begin
          addr_d = addr_q + c_one_addr;
        end
      end
      2'b01: begin
        cnt_d = cnt_q - c_one_cnt;
        if (cnt_q != c_one_cnt) begin
          addr_d = addr_q - c_one_addr;
        end
      end
      default: begin
      end
    endcase
    empty_n_d = (cnt_d != '0);
    full_n_d  = (cnt_d != c_depth_cnt);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  // Explicit compare loop so DEPTH need not be a power of two; addresses past
  // DEPTH-1 are unreachable and read as zero.
  always_comb begin
    w_dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        w_dout = srl_q[i];
      end
    end
  end

  assign if_dout    = w_dout;
  assign if_empty_n = empty_n_q;
  assign if_full_n  = full_n_q;
  assign if_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_linear_layer_start_srl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_linear_layer_start_srl_fifo
//  Purpose  : Self-checking bench for linear_layer_start_srl_fifo with three
//             instances (DEPTH 2, 4 and 5) sharing clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_linear_layer_start_srl_fifo;

  logic clk = 1'b0;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  // DEPTH=2 instance
  logic       d2_din, d2_wr, d2_rd, d2_full_n, d2_dout, d2_empty_n;
  logic [1:0] d2_count;
  // DEPTH=4 instance
  logic [7:0] d4_din, d4_dout;
  logic       d4_wr, d4_rd, d4_full_n, d4_empty_n;
  logic [2:0] d4_count;
  // DEPTH=5 instance
  logic [7:0] d5_din, d5_dout;
  logic       d5_wr, d5_rd, d5_full_n, d5_empty_n;
  logic [3:0] d5_count;

  linear_layer_start_srl_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) u_d2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_din(d2_din), .if_write(d2_wr), .if_full_n(d2_full_n),
    .if_dout(d2_dout), .if_read(d2_rd), .if_empty_n(d2_empty_n),
    .if_count(d2_count)
  );

  linear_layer_start_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_d4 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_din(d4_din), .if_write(d4_wr), .if_full_n(d4_full_n),
    .if_dout(d4_dout), .if_read(d4_rd), .if_empty_n(d4_empty_n),
    .if_count(d4_count)
  );

  linear_layer_start_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(5)) u_d5 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_din(d5_din), .if_write(d5_wr), .if_full_n(d5_full_n),
    .if_dout(d5_dout), .if_read(d5_rd), .if_empty_n(d5_empty_n),
    .if_count(d5_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model_q[$];
  logic       wr_ok, rd_ok;

  initial begin
    rst_n  = 1'b1;
    d2_din = 1'b0; d2_wr = 1'b0; d2_rd = 1'b0;
    d4_din = 8'h0; d4_wr = 1'b0; d4_rd = 1'b0;
    d5_din = 8'h0; d5_wr = 1'b0; d5_rd = 1'b0;

    // ---------------- Reset, no clock edge yet ----------------
    #1 rst_n = 1'b0;
    #1;
    check("rst_empty_n", 32'(d2_empty_n), 32'd0);
    check("rst_full_n",  32'(d2_full_n),  32'd1);
    check("rst_count",   32'(d2_count),   32'd0);
    check("rst_d4_count", 32'(d4_count),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_empty_n", 32'(d2_empty_n), 32'd0);
    check("idle_full_n",  32'(d2_full_n),  32'd1);
    check("idle_count",   32'(d2_count),   32'd0);

    // ---------------- Fill/drain, DEPTH=2 ----------------
    d2_wr = 1'b1; d2_din = 1'b1;
    tick();
    check("d2_first_visible", 32'(d2_empty_n), 32'd1);
    d2_din = 1'b0;
    tick();
    check("d2_full_n",  32'(d2_full_n), 32'd0);
    check("d2_count2",  32'(d2_count),  32'd2);
    d2_din = 1'b1;  // third write must be ignored
    tick();
    check("d2_count_ovf", 32'(d2_count), 32'd2);
    d2_wr = 1'b0; d2_rd = 1'b1;
    check("d2_rd0", 32'(d2_dout), 32'd1);
    tick();
    check("d2_rd1", 32'(d2_dout), 32'd0);
    tick();
    d2_rd = 1'b0;
    check("d2_drain_empty_n", 32'(d2_empty_n), 32'd0);
    check("d2_drain_count",   32'(d2_count),   32'd0);
    check("d2_drain_full_n",  32'(d2_full_n),  32'd1);

    // ---------------- Simultaneous read/write, DEPTH=4 ----------------
    d4_wr = 1'b1; d4_din = 8'hA0;
    tick();
    d4_din = 8'hA1;
    tick();
    check("d4_preload_count", 32'(d4_count), 32'd2);
    for (int i = 0; i < 6; i++) begin
      d4_din = 8'hA2 + 8'(i);
      d4_rd  = 1'b1;
      check("d4_rw_dout", 32'(d4_dout), 32'(8'hA0 + 8'(i)));
      tick();
      check("d4_rw_count", 32'(d4_count), 32'd2);
    end
    // Remaining: A6, A7. Fill to FULL with A8, A9.
    d4_rd = 1'b0; d4_din = 8'hA8;
    tick();
    d4_din = 8'hA9;
    tick();
    d4_wr = 1'b0;
    check("d4_full_count",  32'(d4_count),  32'd4);
    check("d4_full_full_n", 32'(d4_full_n), 32'd0);

    // ---------------- FULL with write+read: read only ----------------
    d4_wr = 1'b1; d4_rd = 1'b1; d4_din = 8'hBB;
    check("d4_full_rw_dout", 32'(d4_dout), 32'h0A6);
    tick();
    d4_wr = 1'b0;
    check("d4_full_rw_count", 32'(d4_count), 32'd3);
    check("d4_full_rw_full_n", 32'(d4_full_n), 32'd1);
    check("d4_drain0", 32'(d4_dout), 32'h0A7);
    tick();
    check("d4_drain1", 32'(d4_dout), 32'h0A8);
    tick();
    check("d4_drain2", 32'(d4_dout), 32'h0A9);
    tick();
    d4_rd = 1'b0;
    check("d4_empty_count",   32'(d4_count),   32'd0);
    check("d4_empty_empty_n", 32'(d4_empty_n), 32'd0);

    // ---------------- EMPTY with write+read: write only ----------------
    d4_wr = 1'b1; d4_rd = 1'b1; d4_din = 8'h55;
    tick();
    d4_wr = 1'b0; d4_rd = 1'b0;
    check("d4_empty_rw_count",   32'(d4_count),   32'd1);
    check("d4_empty_rw_empty_n", 32'(d4_empty_n), 32'd1);
    check("d4_empty_rw_dout",    32'(d4_dout),    32'h055);

    // ---------------- Reset mid-stream ----------------
    d4_wr = 1'b1; d4_din = 8'h66;
    tick();
    d4_din = 8'h77;
    tick();
    d4_wr = 1'b0;
    check("d4_pre_rst_count", 32'(d4_count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("d4_async_empty_n", 32'(d4_empty_n), 32'd0);
    check("d4_async_full_n",  32'(d4_full_n),  32'd1);
    check("d4_async_count",   32'(d4_count),   32'd0);
    #1 rst_n = 1'b1;
    tick();
    d4_wr = 1'b1; d4_din = 8'h01;
    tick();
    d4_wr = 1'b0;
    check("d4_post_rst_empty_n", 32'(d4_empty_n), 32'd1);
    check("d4_post_rst_dout",    32'(d4_dout),    32'h001);
    check("d4_post_rst_count",   32'(d4_count),   32'd1);

    // ---------------- Random traffic, DEPTH=5, against a queue ----------------
    model_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      d5_wr  = 1'($urandom_range(0, 1));
      d5_rd  = 1'($urandom_range(0, 1));
      d5_din = 8'($urandom);
      check("d5_count",   32'(d5_count),   32'(model_q.size()));
      check("d5_empty_n", 32'(d5_empty_n), 32'(model_q.size() != 0));
      check("d5_full_n",  32'(d5_full_n),  32'(model_q.size() != 5));
      if (model_q.size() != 0) begin
        check("d5_dout", 32'(d5_dout), 32'(model_q[0]));
      end
      wr_ok = d5_wr && (model_q.size() != 5);
      rd_ok = d5_rd && (model_q.size() != 0);
      tick();
      if (rd_ok) void'(model_q.pop_front());
      if (wr_ok) model_q.push_back(d5_din);
    end
    d5_wr = 1'b0; d5_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
